prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: ADDR_W, default 4, RAM address width; RAM depth = 2**ADDR_W.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a load session; sampled only in IDLE.
REQ-005 len  input  ADDR_W+1  byte count, sampled with start; 0 means 2**ADDR_W.
REQ-006 abort  input  1  cancel session; effective only in WAIT.
REQ-007 in_valid  input  1  host byte available.
REQ-008 in_data  input  8  host byte.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 bus_out  output  8  value driven onto the shared bus.
REQ-011 bus_oe  output  1  loader owns the bus; all other bus drivers stay off.
REQ-012 marwa  output  1  memory-address-register write strobe.
REQ-013 ramwa  output  1  RAM write strobe.
REQ-014 cpu_hold  output  1  holds the CPU (PC, control counter) in clear while high.
REQ-015 busy  output  1  session in progress.
REQ-016 done  output  1  one-cycle pulse on successful completion.
REQ-017 aborted  output  1  one-cycle pulse on abort.
REQ-018 loaded  output  ADDR_W+1  bytes written in the current or last session.

Function
REQ-019 FSM states: IDLE, WAIT, ADDR, DATA, FIN; all outputs registered.
REQ-020 IDLE: start=1 -> WAIT; latch len; addr=0; loaded=0; cpu_hold=1 and busy=1 from the next cycle.
REQ-021 IDLE with start=0 stays in IDLE; start in any other state is ignored.
REQ-022 WAIT: in_ready=1; handshake on in_valid&in_ready at an edge; latch in_data -> ADDR.
REQ-023 ADDR (one cycle): bus_oe=1, bus_out={zeros, addr}, marwa=1 -> DATA.
REQ-024 DATA (one cycle): bus_oe=1, bus_out=latched byte, ramwa=1; loaded increments at the exit edge.
REQ-025 DATA exit: if addr == effective_len-1 -> FIN; else addr+1 -> WAIT.
REQ-026 Timing: a byte accepted at edge N gives marwa in cycle N+1, ramwa in cycle N+2, and in_ready=1 again in cycle N+3. Peak throughput is one byte per 3 cycles.
REQ-027 marwa and ramwa are never high in the same cycle.
REQ-028 bus_oe=0 and bus_out=0 in every state except ADDR and DATA.
REQ-029 FIN (one cycle): done=1, cpu_hold drops to 0 and busy drops to 0 at the exit edge -> IDLE.
REQ-030 abort=1 in WAIT at an edge -> IDLE; aborted=1 for one cycle; cpu_hold=0; done is not pulsed.
REQ-031 abort and in_valid both high in WAIT: abort wins and the byte is not accepted.
REQ-032 abort in ADDR or DATA is ignored; the write in progress completes.
REQ-033 addr never exceeds effective_len-1; no wrap occurs within a session.
REQ-034 len=0 loads all 2**ADDR_W locations.
REQ-035 loaded holds its final value in IDLE until the next start.

Reset
REQ-036 clr=1 forces IDLE immediately, independent of clk.
REQ-037 While clr=1: all outputs 0, including loaded, addr and the latched byte.
REQ-038 clr asserted mid-write removes marwa and ramwa asynchronously and leaves no partial strobe after release.
REQ-039 After clr deasserts, the first start is accepted at the next rising edge.

Verification
REQ-040 len=3, bytes 0xA1, 0xB2, 0xC3 sent back-to-back -> MAR/RAM pairs (0,0xA1), (1,0xB2), (2,0xC3); done pulses once; loaded=3; cpu_hold=0 afterwards.
REQ-041 len=0 with 16 bytes 0x00..0x0F -> addresses 0..15 written in order; loaded=16; no 17th write.
REQ-042 in_valid is held low for 5 cycles in WAIT -> the FSM stays in WAIT with in_ready=1, and bus_oe, marwa and ramwa stay 0.
REQ-043 len=4 with abort raised after 2 bytes, in the same cycle as in_valid -> exactly 2 writes; aborted pulses; done does not pulse; loaded=2.
REQ-044 clr pulsed during DATA of byte 1 -> ramwa falls immediately; all outputs are 0; a new start with len=1 and byte 0x5A -> write to address 0, then done.
REQ-045 start pulsed during WAIT -> ignored; len is not relatched; the session completes with the original count.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - host-to-RAM program loader that owns the shared bus while it writes
//
// Loads a program into a 2**ADDR_W deep RAM through the machine's shared bus.
// Each host byte takes one MAR write cycle and then one RAM write cycle.
// The CPU is held in clear for the whole session.
//
// Ports:
//   clk       system clock, rising edge
//   clr       asynchronous active-high reset
//   start     begin a session (sampled in IDLE only)
//   len       byte count latched with start, 0 = full RAM depth
//   abort     cancel the session (effective only while waiting for a byte)
//   in_valid  host byte available
//   in_data   host byte
//   in_ready  loader accepts a byte this cycle
//   bus_out   value driven onto the shared bus
//   bus_oe    loader owns the bus
//   marwa     memory-address-register write strobe
//   ramwa     RAM write strobe
//   cpu_hold  CPU held in clear
//   busy      session in progress
//   done      one-cycle pulse on successful completion
//   aborted   one-cycle pulse on abort
//   loaded    bytes written in the current or last session
module prog_loader #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [7:0]        bus_out,
   output logic              bus_oe,
   output logic              marwa,
   output logic              ramwa,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [ADDR_W:0]   loaded
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_ADDR = 3'd2,
      S_DATA = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   localparam logic [ADDR_W:0]   DEPTH   = (ADDR_W+1)'(1) << ADDR_W;
   localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);

   state_t            state, state_n;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        byte_q;
   logic [ADDR_W:0]   eff_len;
   logic              last;
   logic              take;

   logic              in_ready_n, bus_oe_n, marwa_n, ramwa_n;
   logic              hold_n, done_n, aborted_n;
   logic [7:0]        bus_out_n;

   // Counts above the RAM depth are clamped so the address can never wrap.
   always_comb begin
      eff_len = len_q;
      if (len_q == '0 || len_q > DEPTH)
         eff_len = DEPTH;
   end

   assign last = ({1'b0, addr} == (eff_len - LEN_ONE));
   // Abort has priority over a byte offered in the same cycle.
   assign take = (state == S_WAIT) && !abort && in_valid;

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   // Outputs are decoded from the next state so that every output comes
   // straight from a flop and lines up with the state it belongs to.
   always_comb begin
      state_n    = state;
      in_ready_n = 1'b0;
      bus_oe_n   = 1'b0;
      marwa_n    = 1'b0;
      ramwa_n    = 1'b0;
      hold_n     = 1'b0;
      done_n     = 1'b0;
      aborted_n  = 1'b0;
      bus_out_n  = 8'h00;

      case (state)
         S_IDLE: if (start) state_n = S_WAIT;
         S_WAIT: begin
            if (abort)
               state_n = S_IDLE;
            else if (in_valid)
               state_n = S_ADDR;
         end
         S_ADDR: state_n = S_DATA;
         S_DATA: state_n = last ? S_FIN : S_WAIT;
         S_FIN:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      in_ready_n = (state_n == S_WAIT);
      marwa_n    = (state_n == S_ADDR);
      ramwa_n    = (state_n == S_DATA);
      bus_oe_n   = marwa_n || ramwa_n;
      hold_n     = (state_n != S_IDLE);
      done_n     = (state_n == S_FIN);
      aborted_n  = (state == S_WAIT) && abort;
      if (marwa_n)
         bus_out_n = 8'(addr);
      else if (ramwa_n)
         bus_out_n = byte_q;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         len_q    <= '0;
         addr     <= '0;
         byte_q   <= 8'h00;
         loaded   <= '0;
         in_ready <= 1'b0;
         bus_out  <= 8'h00;
         bus_oe   <= 1'b0;
         marwa    <= 1'b0;
         ramwa    <= 1'b0;
         cpu_hold <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         in_ready <= in_ready_n;
         bus_out  <= bus_out_n;
         bus_oe   <= bus_oe_n;
         marwa    <= marwa_n;
         ramwa    <= ramwa_n;
         cpu_hold <= hold_n;
         busy     <= hold_n;
         done     <= done_n;
         aborted  <= aborted_n;

         if (state == S_IDLE && start) begin
            len_q  <= len;
            addr   <= '0;
            loaded <= '0;
         end
         if (take)
            byte_q <= in_data;
         if (state == S_DATA) begin
            loaded <= loaded + LEN_ONE;
            if (!last)
               addr <= addr + A_ONE;
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       start = 1'b0;
   logic [4:0] len = 5'd0;
   logic       abort = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic [7:0] bus_out;
   logic       bus_oe, marwa, ramwa, cpu_hold, busy, done, aborted;
   logic [4:0] loaded;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  mar_cap = 8'h00;
   logic [15:0] wr_q[$];
   int          done_cnt = 0;
   int          abort_cnt = 0;
   int          overlap = 0;
   int          d0, a0;

   prog_loader #(.ADDR_W(4)) dut (
      .clk(clk), .clr(clr), .start(start), .len(len), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .bus_out(bus_out), .bus_oe(bus_oe), .marwa(marwa), .ramwa(ramwa),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .aborted(aborted),
      .loaded(loaded)
   );

   always #5 clk = ~clk;

   // Bus observer: records each (MAR, RAM data) write pair and pulse counts.
   always @(posedge clk) begin
      if (marwa) mar_cap <= bus_out;
      if (ramwa) wr_q.push_back({mar_cap, bus_out});
      if (done) done_cnt <= done_cnt + 1;
      if (aborted) abort_cnt <= abort_cnt + 1;
      if (marwa && ramwa) overlap <= overlap + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_bus_oe"}, bus_oe, 0);
      chk({tag, "_bus_out"}, bus_out, 0);
      chk({tag, "_marwa"}, marwa, 0);
      chk({tag, "_ramwa"}, ramwa, 0);
      chk({tag, "_cpu_hold"}, cpu_hold, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Called on a negedge with the DUT in IDLE; returns on the first WAIT negedge.
   task automatic do_start(input logic [4:0] l);
      start = 1'b1;
      len = l;
      @(negedge clk);
      start = 1'b0;
      len = 5'd0;
      chk("start_in_ready", in_ready, 1);
      chk("start_busy", busy, 1);
      chk("start_cpu_hold", cpu_hold, 1);
      chk("start_loaded", loaded, 0);
   endtask

   // Hands one byte over and checks the ADDR and DATA cycles; returns on the DATA negedge.
   task automatic send_byte(input logic [7:0] b, input logic [7:0] a);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", (n < 20), 1);
      in_valid = 1'b1;
      in_data = b;
      @(negedge clk);
      in_valid = 1'b0;
      in_data = 8'h00;
      chk("addr_marwa", marwa, 1);
      chk("addr_ramwa", ramwa, 0);
      chk("addr_bus_oe", bus_oe, 1);
      chk("addr_bus_out", bus_out, a);
      chk("addr_in_ready", in_ready, 0);
      @(negedge clk);
      chk("data_ramwa", ramwa, 1);
      chk("data_marwa", marwa, 0);
      chk("data_bus_oe", bus_oe, 1);
      chk("data_bus_out", bus_out, b);
   endtask

   // From the DATA negedge of the final byte: expect FIN, then IDLE.
   task automatic finish_session(input logic [4:0] exp_loaded);
      @(negedge clk);
      chk("fin_done", done, 1);
      chk("fin_in_ready", in_ready, 0);
      chk("fin_cpu_hold", cpu_hold, 1);
      chk("fin_loaded", loaded, exp_loaded);
      @(negedge clk);
      chk("post_done", done, 0);
      chk_idle_outputs("post");
      chk("post_loaded", loaded, exp_loaded);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state while clr is held.
      @(negedge clk);
      @(negedge clk);
      chk_idle_outputs("rst");
      chk("rst_loaded", loaded, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);

      // len=3, three back-to-back bytes; start accepted at the first edge after clr release.
      clr = 1'b0;
      d0 = done_cnt;
      do_start(5'd3);
      wr_q.delete();
      send_byte(8'hA1, 8'd0);
      @(negedge clk);
      chk("b2b_ready_n3", in_ready, 1);
      send_byte(8'hB2, 8'd1);
      send_byte(8'hC3, 8'd2);
      finish_session(5'd3);
      chk("s1_wr_count", wr_q.size(), 3);
      chk("s1_wr0", wr_q[0], 16'h00A1);
      chk("s1_wr1", wr_q[1], 16'h01B2);
      chk("s1_wr2", wr_q[2], 16'h02C3);
      chk("s1_done_cnt", done_cnt - d0, 1);
      // loaded holds in IDLE.
      @(negedge clk);
      @(negedge clk);
      chk("s1_loaded_hold", loaded, 3);

      // len=0 loads all 16 locations and stops.
      d0 = done_cnt;
      do_start(5'd0);
      wr_q.delete();
      for (int i = 0; i < 16; i++)
         send_byte(8'(i), 8'(i));
      finish_session(5'd16);
      chk("full_wr_count", wr_q.size(), 16);
      for (int i = 0; i < 16; i++)
         chk("full_wr", wr_q[i], {8'(i), 8'(i)});
      chk("full_done_cnt", done_cnt - d0, 1);

      // Idle host for 5 cycles in WAIT, plus a stray start that must not relatch len.
      d0 = done_cnt;
      do_start(5'd2);
      wr_q.delete();
      for (int i = 0; i < 5; i++) begin
         chk("stall_in_ready", in_ready, 1);
         chk("stall_bus_oe", bus_oe, 0);
         chk("stall_marwa", marwa, 0);
         chk("stall_ramwa", ramwa, 0);
         if (i == 2) begin
            start = 1'b1;
            len = 5'd5;
         end else begin
            start = 1'b0;
            len = 5'd0;
         end
         @(negedge clk);
      end
      chk("stall_still_wait", in_ready, 1);
      send_byte(8'h3C, 8'd0);
      send_byte(8'h4D, 8'd1);
      finish_session(5'd2);
      chk("relatch_wr_count", wr_q.size(), 2);
      chk("relatch_done_cnt", done_cnt - d0, 1);

      // len=4, abort together with the third byte.
      d0 = done_cnt;
      a0 = abort_cnt;
      do_start(5'd4);
      wr_q.delete();
      send_byte(8'h11, 8'd0);
      send_byte(8'h22, 8'd1);
      @(negedge clk);
      chk("abort_pre_ready", in_ready, 1);
      abort = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h33;
      @(negedge clk);
      abort = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      chk("abort_pulse", aborted, 1);
      chk("abort_done", done, 0);
      chk("abort_loaded", loaded, 2);
      chk_idle_outputs("abort");
      @(negedge clk);
      chk("abort_pulse_end", aborted, 0);
      chk("abort_wr_count", wr_q.size(), 2);
      chk("abort_cnt", abort_cnt - a0, 1);
      chk("abort_no_done", done_cnt - d0, 0);

      // clr in the middle of the second byte's RAM write.
      do_start(5'd3);
      wr_q.delete();
      send_byte(8'h77, 8'd0);
      send_byte(8'h88, 8'd1);
      #2;
      clr = 1'b1;
      #1;
      chk("clr_ramwa", ramwa, 0);
      chk_idle_outputs("clr");
      chk("clr_loaded", loaded, 0);
      @(negedge clk);
      chk("clr_hold_ramwa", ramwa, 0);
      chk("clr_wr_count", wr_q.size(), 1);
      clr = 1'b0;
      d0 = done_cnt;
      do_start(5'd1);
      wr_q.delete();
      send_byte(8'h5A, 8'd0);
      finish_session(5'd1);
      chk("clr_new_wr_count", wr_q.size(), 1);
      chk("clr_new_wr0", wr_q[0], 16'h005A);
      chk("clr_new_done", done_cnt - d0, 1);

      chk("strobe_overlap", overlap, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
